// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM states, default
// timing constants and the frame layout.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int FILTER_LEN_DEF     = 8;
  localparam int TIMEOUT_CYCLES_DEF = 20000;
  // start + 8 data + parity + stop
  localparam int FRAME_BITS         = 11;
  localparam int DATA_BITS          = FRAME_BITS - 3;

  // PS/2 uses odd parity across the data byte and the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchronizer followed by a run-length filter for one PS/2 line.
// The output only moves after FILTER_LEN consecutive samples disagree with it.
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_out
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic          filt_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Everything presets to 1 so an idle line never produces a spurious edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign line_out = filt_q;

endmodule

// File: rtl/ps2_rx.sv
// Receive-only PS/2 device-to-host byte receiver: filtered clock edges drive
// a start/data/parity/stop FSM with a mid-frame inactivity timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_f;
  logic dat_f;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk      (clk),
    .reset    (reset),
    .line_in  (ps2_clk),
    .line_out (clk_f)
  );

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk      (clk),
    .reset    (reset),
    .line_in  (ps2_data),
    .line_out (dat_f)
  );

  logic          clk_prev_q;
  logic          fall_q;
  logic          edge_q;
  logic          bit_q;
  ps2_state_e    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    to_d       = to_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;

    if (fall_q) begin
      to_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!bit_q) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          shift_d = {bit_q, shift_q[7:1]};
          if (cnt_q == 3'(DATA_BITS - 1)) begin
            state_d = ST_PARITY;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_PARITY: begin
          par_d   = bit_q;
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (!bit_q) begin
            ferr_d = 1'b1;
          end else if (odd_parity_ok(shift_q, par_q)) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      // Any filtered clock transition proves the device is still talking.
      if (edge_q) begin
        to_d = '0;
      end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
        to_d    = '0;
        ferr_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        to_d = to_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
      edge_q     <= 1'b0;
      bit_q      <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_q       <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      clk_prev_q <= clk_f;
      fall_q     <= clk_prev_q & ~clk_f;
      edge_q     <= clk_prev_q ^ clk_f;
      bit_q      <= dat_f;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_q       <= to_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Randomized self-checking bench for ps2_rx against a frame-level outcome model.
module tb_ps2_rx;

  localparam int F    = 8;
  localparam int TO   = 400;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;

  ps2_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int overlap = 0;
  int stop_cyc = 0;
  int rise_cyc = 0;
  logic [7:0] model_data = 8'h00;

  typedef struct {
    int         kind;   // 0 valid, 1 parity error, 2 frame error
    logic [7:0] data;
    int         cyc;
  } ev_t;
  ev_t evq[$];
  ev_t ev_m;
  logic pv = 1'b0, pp = 1'b0, pf = 1'b0;

  always @(negedge clk) begin
    if ((int'(rx_valid) + int'(parity_err) + int'(frame_err)) > 1) overlap++;
    if ((rx_valid && pv) || (parity_err && pp) || (frame_err && pf)) overlap++;
    pv = rx_valid; pp = parity_err; pf = frame_err;
    if (rx_valid)   begin ev_m.kind = 0; ev_m.data = rx_data; ev_m.cyc = cyc; evq.push_back(ev_m); end
    if (parity_err) begin ev_m.kind = 1; ev_m.data = rx_data; ev_m.cyc = cyc; evq.push_back(ev_m); end
    if (frame_err)  begin ev_m.kind = 2; ev_m.data = rx_data; ev_m.cyc = cyc; evq.push_back(ev_m); end
  end

  // Frame outcome from the protocol rules: stop bit first, then odd parity.
  function automatic int model_kind(input logic [7:0] d, input logic par, input logic stop);
    int ones;
    if (!stop) return 2;
    ones = int'(par);
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 1) ? 0 : 1;
  endfunction

  function automatic logic good_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int nbits);
    logic [10:0] fr;
    fr = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2_data = fr[i];
      repeat (HALF - 1) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
      rise_cyc = cyc;
    end
    @(posedge clk); #1 ps2_data = 1'b1;
  endtask

  task automatic settle();
    repeat (F + 30) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    reset = 1'b1;
    repeat (20) @(posedge clk);
    evq.delete();
  endtask

  task automatic test_single();
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    settle();
    model_data = 8'h1C;
    n_cmp++;
    if (evq.size() !== 1) begin n_bad++; $display("FAIL single_count got=%0d exp=1", evq.size()); end
    else begin
      n_cmp++; if (evq[0].kind !== 0 || evq[0].data !== 8'h1C) begin n_bad++; $display("FAIL single_event got kind=%0d data=%h exp kind=0 data=1c", evq[0].kind, evq[0].data); end
      n_cmp++; if (evq[0].cyc - stop_cyc !== F + 4) begin n_bad++; $display("FAIL single_latency got=%0d exp=%0d", evq[0].cyc - stop_cyc, F + 4); end
    end
    n_cmp++; if (rx_data !== 8'h1C) begin n_bad++; $display("FAIL single_hold got=%h exp=1c", rx_data); end
    evq.delete();
  endtask

  task automatic test_back_to_back();
    send_frame(8'hF0, good_par(8'hF0), 1'b1, 11);
    send_frame(8'h1C, good_par(8'h1C), 1'b1, 11);
    settle();
    model_data = 8'h1C;
    n_cmp++;
    if (evq.size() !== 2) begin n_bad++; $display("FAIL b2b_count got=%0d exp=2", evq.size()); end
    else begin
      n_cmp++; if (evq[0].kind !== 0 || evq[0].data !== 8'hF0) begin n_bad++; $display("FAIL b2b_first got kind=%0d data=%h exp kind=0 data=f0", evq[0].kind, evq[0].data); end
      n_cmp++; if (evq[1].kind !== 0 || evq[1].data !== 8'h1C) begin n_bad++; $display("FAIL b2b_second got kind=%0d data=%h exp kind=0 data=1c", evq[1].kind, evq[1].data); end
    end
    evq.delete();
  endtask

  task automatic test_parity_err();
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    settle();
    n_cmp++;
    if (evq.size() !== 1) begin n_bad++; $display("FAIL perr_count got=%0d exp=1", evq.size()); end
    else begin
      n_cmp++; if (evq[0].kind !== 1) begin n_bad++; $display("FAIL perr_kind got=%0d exp=1", evq[0].kind); end
    end
    n_cmp++; if (rx_data !== model_data) begin n_bad++; $display("FAIL perr_hold got=%h exp=%h", rx_data, model_data); end
    evq.delete();
  endtask

  task automatic test_frame_err();
    send_frame(8'h29, good_par(8'h29), 1'b0, 11);
    settle();
    n_cmp++;
    if (evq.size() !== 1) begin n_bad++; $display("FAIL ferr_count got=%0d exp=1", evq.size()); end
    else begin
      n_cmp++; if (evq[0].kind !== 2) begin n_bad++; $display("FAIL ferr_kind got=%0d exp=2", evq[0].kind); end
    end
    n_cmp++; if (rx_data !== model_data) begin n_bad++; $display("FAIL ferr_hold got=%h exp=%h", rx_data, model_data); end
    evq.delete();
    send_frame(8'h29, good_par(8'h29), 1'b1, 11);
    settle();
    model_data = 8'h29;
    n_cmp++;
    if (evq.size() !== 1 || evq[0].kind !== 0 || rx_data !== 8'h29) begin
      n_bad++; $display("FAIL ferr_recover got events=%0d rx_data=%h exp events=1 rx_data=29", evq.size(), rx_data);
    end
    evq.delete();
  endtask

  task automatic test_timeout();
    send_frame(8'h1C, 1'b0, 1'b1, 5);
    repeat (TO + F + 60) @(posedge clk);
    #1;
    n_cmp++;
    if (evq.size() !== 1) begin n_bad++; $display("FAIL timeout_count got=%0d exp=1", evq.size()); end
    else begin
      n_cmp++; if (evq[0].kind !== 2) begin n_bad++; $display("FAIL timeout_kind got=%0d exp=2", evq[0].kind); end
      n_cmp++;
      if (evq[0].cyc - rise_cyc < TO || evq[0].cyc - rise_cyc > TO + F + 8) begin
        n_bad++; $display("FAIL timeout_delay got=%0d exp=%0d..%0d", evq[0].cyc - rise_cyc, TO, TO + F + 8);
      end
    end
    evq.delete();
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    settle();
    model_data = 8'h1C;
    n_cmp++;
    if (evq.size() !== 1 || evq[0].kind !== 0 || rx_data !== 8'h1C) begin
      n_bad++; $display("FAIL timeout_recover got events=%0d rx_data=%h exp events=1 rx_data=1c", evq.size(), rx_data);
    end
    evq.delete();
  endtask

  task automatic test_glitch_reset();
    for (int g = 0; g < 4; g++) begin
      @(posedge clk); #1 ps2_clk = 1'b0;
      repeat (5) @(posedge clk);
      #1 ps2_clk = 1'b1;
      repeat (30) @(posedge clk);
    end
    send_frame(8'hA5, 1'b0, 1'b1, 4);
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    model_data = 8'h00;
    repeat (TO + F + 60) @(posedge clk);
    #1;
    n_cmp++;
    if (evq.size() !== 0) begin n_bad++; $display("FAIL glitch_reset_events got=%0d exp=0", evq.size()); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL glitch_reset_data got=%h exp=00", rx_data); end
    evq.delete();
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    settle();
    model_data = 8'h1C;
    n_cmp++;
    if (evq.size() !== 1 || evq[0].kind !== 0 || rx_data !== 8'h1C) begin
      n_bad++; $display("FAIL glitch_recover got events=%0d rx_data=%h exp events=1 rx_data=1c", evq.size(), rx_data);
    end
    evq.delete();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       par;
    logic       stop;
    int         flaw;
    int         k;
    for (int n = 0; n < 14; n++) begin
      d    = 8'($urandom_range(0, 255));
      flaw = $urandom_range(0, 3);
      par  = good_par(d) ^ (flaw == 2);
      stop = (flaw != 3);
      if (flaw == 3) par = 1'($urandom_range(0, 1));
      k = model_kind(d, par, stop);
      if (k == 0) model_data = d;
      send_frame(d, par, stop, 11);
      settle();
      n_cmp++;
      if (evq.size() !== 1) begin n_bad++; $display("FAIL rand_count frame=%0d got=%0d exp=1", n, evq.size()); end
      else if (evq[0].kind !== k) begin n_bad++; $display("FAIL rand_kind frame=%0d data=%h got=%0d exp=%0d", n, d, evq[0].kind, k); end
      n_cmp++; if (rx_data !== model_data) begin n_bad++; $display("FAIL rand_data frame=%0d got=%h exp=%h", n, rx_data, model_data); end
      evq.delete();
    end
  endtask

  task automatic test_exclusive();
    n_cmp++;
    if (overlap !== 0) begin n_bad++; $display("FAIL pulse_exclusive got=%0d exp=0", overlap); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity_err();
    test_frame_err();
    test_timeout();
    test_glitch_reset();
    test_random();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
